// File: rtl/pwm_counter.sv
// pwm_counter: prescaled 16-bit up/down PWM timebase with a registered wrap pulse.
// Optional COUNTER_SHADOW_EN: period/prescale are taken from shadow registers loaded at safe points.
module pwm_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PRE_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             count_reset,
  input  logic             upnotdown,
  input  logic [CNT_W-1:0] period,
  input  logic [PRE_W-1:0] prescale,
  output logic [CNT_W-1:0] counter_val,
  output logic             tick,
  output logic             wrap
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_period_eff;
  logic [PRE_W-1:0] r_pre;
  logic [PRE_W-1:0] w_pre_nxt;
  logic [PRE_W-1:0] w_prescale_eff;
  logic             r_wrap;
  logic             w_tick;
  logic             w_wrap_gen;

`ifdef COUNTER_SHADOW_EN
  logic [CNT_W-1:0] r_period_sh;
  logic [PRE_W-1:0] r_prescale_sh;
  logic             w_shadow_load;

  // Reload only while idle, on clear, or at a period boundary so a running period is never cut
  assign w_shadow_load = ~en | count_reset | w_wrap_gen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period_sh   <= '0;
      r_prescale_sh <= '0;
    end else if (w_shadow_load) begin
      r_period_sh   <= period;
      r_prescale_sh <= prescale;
    end
  end

  assign w_period_eff   = r_period_sh;
  assign w_prescale_eff = r_prescale_sh;
`else
  assign w_period_eff   = period;
  assign w_prescale_eff = prescale;
`endif

  // >= lets a prescale reduction take effect at once instead of waiting for pre_cnt to roll over
  assign w_tick = en & ~count_reset & (r_pre >= w_prescale_eff);

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_pre_nxt  = r_pre;
    w_wrap_gen = 1'b0;
    if (count_reset) begin
      w_cnt_nxt = '0;
      w_pre_nxt = '0;
    end else if (en) begin
      if (w_tick) begin
        w_pre_nxt = '0;
        if (upnotdown) begin
          if (r_cnt >= w_period_eff) begin
            w_cnt_nxt  = '0;
            w_wrap_gen = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end else begin
          if ((r_cnt == '0) || (r_cnt > w_period_eff)) begin
            w_cnt_nxt  = w_period_eff;
            w_wrap_gen = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
      end else begin
        w_pre_nxt = r_pre + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_pre  <= '0;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_pre  <= w_pre_nxt;
      r_wrap <= w_wrap_gen;
    end
  end

  assign counter_val = r_cnt;
  assign tick        = w_tick;
  assign wrap        = r_wrap;

endmodule

// File: tb/tb_pwm_counter.sv
// Self-checking bench for pwm_counter: directed scenarios plus randomized traffic against a cycle model.
module tb_pwm_counter;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned PRE_W = 8;
`ifdef COUNTER_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             count_reset = 1'b0;
  logic             upnotdown = 1'b1;
  logic [CNT_W-1:0] period = '0;
  logic [PRE_W-1:0] prescale = '0;
  logic [CNT_W-1:0] counter_val;
  logic             tick;
  logic             wrap;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state
  int m_cnt, m_pre, m_per_sh, m_pre_sh;
  bit m_wrap;
  int obs_cnt;
  bit obs_wrap, obs_tick;

  pwm_counter #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .count_reset(count_reset),
    .upnotdown(upnotdown), .period(period), .prescale(prescale),
    .counter_val(counter_val), .tick(tick), .wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  function automatic int eff_per();
    return SHADOW ? m_per_sh : int'(period);
  endfunction

  function automatic int eff_pre();
    return SHADOW ? m_pre_sh : int'(prescale);
  endfunction

  function automatic bit model_tick();
    return en && !count_reset && (m_pre >= eff_pre());
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_pre = 0; m_wrap = 0; m_per_sh = 0; m_pre_sh = 0;
  endtask

  task automatic model_step();
    int pp;
    bit t, wg;
    pp = eff_per();
    t  = model_tick();
    wg = 1'b0;
    if (count_reset) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (en) begin
      if (t) begin
        m_pre = 0;
        if (upnotdown) begin
          if (m_cnt >= pp) begin m_cnt = 0; wg = 1'b1; end
          else m_cnt = (m_cnt + 1) % 65536;
        end else begin
          if (m_cnt == 0 || m_cnt > pp) begin m_cnt = pp; wg = 1'b1; end
          else m_cnt = m_cnt - 1;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    m_wrap = wg;
    if (!en || count_reset || wg) begin
      m_per_sh = int'(period);
      m_pre_sh = int'(prescale);
    end
  endtask

  // One clock: compare outputs to the model mid-cycle, then advance the model on the edge
  task automatic cycle();
    bit et;
    @(negedge clk);
    obs_cnt  = int'(counter_val);
    obs_wrap = wrap;
    obs_tick = tick;
    et = model_tick();
    checks++;
    if (counter_val !== CNT_W'(m_cnt)) begin
      failures++;
      $display("FAIL model_counter cyc=%0d got=%0h exp=%0h", cyc, counter_val, m_cnt);
    end
    checks++;
    if (wrap !== m_wrap) begin
      failures++;
      $display("FAIL model_wrap cyc=%0d got=%0b exp=%0b", cyc, wrap, m_wrap);
    end
    checks++;
    if (tick !== et) begin
      failures++;
      $display("FAIL model_tick cyc=%0d got=%0b exp=%0b", cyc, tick, et);
    end
    @(posedge clk);
    model_step();
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    count_reset = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (counter_val !== '0 || wrap !== 1'b0 || tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got cnt=%0h wrap=%0b tick=%0b exp 0/0/0", counter_val, wrap, tick);
    end
    rst_n = 1'b1;
    model_reset();
    cycle();
  endtask

  task automatic test_reset();
    period = CNT_W'($urandom_range(1, 100));
    prescale = PRE_W'($urandom_range(0, 5));
    do_reset();
  endtask

  task automatic test_up_basic();
    int exp_c[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    period = 16'd3; prescale = 8'd0; upnotdown = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      checks++;
      if (obs_cnt != exp_c[i] || obs_wrap != (i == 4 || i == 8)) begin
        failures++;
        $display("FAIL up_basic i=%0d got cnt=%0d wrap=%0b exp cnt=%0d wrap=%0b",
                 i, obs_cnt, obs_wrap, exp_c[i], (i == 4 || i == 8));
      end
    end
  endtask

  task automatic test_prescale();
    int n;
    period = 16'd2; prescale = 8'd2; upnotdown = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      cycle();
      checks++;
      if (obs_cnt != (i / 3) % 3 || obs_wrap != (i == 9 || i == 18)) begin
        failures++;
        $display("FAIL prescale_seq i=%0d got cnt=%0d wrap=%0b exp cnt=%0d wrap=%0b",
                 i, obs_cnt, obs_wrap, (i / 3) % 3, (i == 9 || i == 18));
      end
    end
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      en = (k >= 5 && k <= 9) ? 1'b0 : 1'b1;
      cycle();
      n = k;
      if (k >= 5 && k <= 10) begin
        checks++;
        if (obs_cnt != 1) begin
          failures++;
          $display("FAIL prescale_freeze k=%0d got cnt=%0d exp 1", k, obs_cnt);
        end
      end
      if (obs_wrap) break;
    end
    en = 1'b1;
    checks++;
    if (n != 14) begin
      failures++;
      $display("FAIL prescale_wrap_gap got=%0d exp=14", n);
    end
  endtask

  task automatic test_down();
    int exp_c[7] = '{0, 4, 3, 2, 1, 0, 4};
    period = 16'd4; prescale = 8'd0; upnotdown = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle();
      checks++;
      if (obs_cnt != exp_c[i] || obs_wrap != (i == 1 || i == 6)) begin
        failures++;
        $display("FAIL down_seq i=%0d got cnt=%0d wrap=%0b exp cnt=%0d wrap=%0b",
                 i, obs_cnt, obs_wrap, exp_c[i], (i == 1 || i == 6));
      end
    end
  endtask

  task automatic test_count_reset();
    period = 16'hFFFF; prescale = 8'd0; upnotdown = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 256; i++) cycle();
    count_reset = 1'b1;
    cycle();
    checks++;
    if (obs_cnt != 16'h0100) begin
      failures++;
      $display("FAIL cr_start got=%0h exp=100", obs_cnt);
    end
    cycle();
    checks++;
    if (obs_cnt != 0 || obs_wrap || obs_tick) begin
      failures++;
      $display("FAIL cr_hold got cnt=%0h wrap=%0b tick=%0b exp 0/0/0", obs_cnt, obs_wrap, obs_tick);
    end
    count_reset = 1'b0;
    cycle();
    checks++;
    if (obs_cnt != 0 || !obs_tick) begin
      failures++;
      $display("FAIL cr_release got cnt=%0h tick=%0b exp 0/1", obs_cnt, obs_tick);
    end
    cycle();
    checks++;
    if (obs_cnt != 1) begin
      failures++;
      $display("FAIL cr_resume got=%0h exp=1", obs_cnt);
    end
  endtask

  task automatic test_period_change();
`ifdef COUNTER_SHADOW_EN
    int exp_c[10] = '{8, 9, 10, 0, 1, 2, 3, 4, 5, 0};
    localparam int NSEQ = 10;
`else
    int exp_c[8] = '{8, 0, 1, 2, 3, 4, 5, 0};
    localparam int NSEQ = 8;
`endif
    period = 16'd10; prescale = 8'd0; upnotdown = 1'b1;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    period = 16'd5;
    for (int i = 0; i < NSEQ; i++) begin
      cycle();
      checks++;
      if (obs_cnt != exp_c[i] || obs_wrap != (exp_c[i] == 0)) begin
        failures++;
        $display("FAIL period_change i=%0d got cnt=%0d wrap=%0b exp cnt=%0d wrap=%0b",
                 i, obs_cnt, obs_wrap, exp_c[i], (exp_c[i] == 0));
      end
    end
  endtask

  task automatic test_max_period();
    int exp_c[6] = '{16'h0000, 16'hFFFF, 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    bit exp_w[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    period = 16'hFFFF; prescale = 8'd0; upnotdown = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) upnotdown = 1'b1;
      cycle();
      checks++;
      if (obs_cnt != exp_c[i] || obs_wrap != exp_w[i]) begin
        failures++;
        $display("FAIL max_period i=%0d got cnt=%0h wrap=%0b exp cnt=%0h wrap=%0b",
                 i, obs_cnt, obs_wrap, exp_c[i], exp_w[i]);
      end
    end
    checks++;
    if (counter_val !== 16'd2) begin
      failures++;
      $display("FAIL pre_async got=%0h exp=2", counter_val);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (counter_val !== '0 || wrap !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got cnt=%0h wrap=%0b exp 0/0", counter_val, wrap);
    end
    en = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle();
    en = 1'b1;
    cycle();
    cycle();
    checks++;
    if (obs_cnt != 1) begin
      failures++;
      $display("FAIL post_async_resume got=%0h exp=1", obs_cnt);
    end
  endtask

  task automatic test_random();
    int cr_left;
    cr_left = 0;
    period = 16'd7; prescale = 8'd1; upnotdown = 1'b1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0)
        period = ($urandom_range(0, 9) == 0) ? 16'd0 : CNT_W'($urandom_range(1, 12));
      if ($urandom_range(0, 24) == 0) prescale = PRE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) upnotdown = ~upnotdown;
      en = ($urandom_range(0, 9) != 0);
      if (cr_left == 0 && $urandom_range(0, 59) == 0) cr_left = 2;
      count_reset = (cr_left != 0);
      if (cr_left != 0) cr_left--;
      cycle();
    end
    count_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_basic();
    test_prescale();
    test_down();
    test_count_reset();
    test_period_change();
    test_max_period();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
